// File: rtl/tinydfu_pkg.sv
// Shared types and constants for the TinyDFU boot controller slice.
package tinydfu_pkg;

    // Boot controller state; also used as the LED pattern mode.
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        WAIT   = 2'd1,
        MANUAL = 2'd2,
        BOOT   = 2'd3
    } boot_state_t;

    // dfu_state encoding for dfuIDLE.
    localparam logic [7:0] DFU_STATE_IDLE = 8'h02;

endpackage

// File: rtl/tinydfu_led_pattern.sv
// Status LED pattern generator: free-running counter, idle blink and cylon.
// The pattern is decoded from registered state only (mode, counter, cylon).
module tinydfu_led_pattern
    import tinydfu_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int BLINK_BIT      = 21,
    parameter int CYLON_BIT      = 20,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    boot_state_t         mode_st;
    logic [31:0]         led_cnt;
    logic [31:0]         led_cnt_nxt;
    logic                cylon_step;
    logic [POS_W-1:0]    cylon_pos;
    logic                cylon_up;
    logic [NUM_LEDS-1:0] pattern;

    assign mode_st     = boot_state_t'(mode);
    assign led_cnt_nxt = led_cnt + 32'd1;
    // Single-cycle enable on the edge where CYLON_BIT flips.
    assign cylon_step  = led_cnt_nxt[CYLON_BIT] ^ led_cnt[CYLON_BIT];

    // Free-running 32-bit LED timebase; never cleared by state changes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) led_cnt <= '0;
        else         led_cnt <= led_cnt_nxt;
    end

    // Cylon position: parked at LED0 outside MANUAL, bounces 0..N-1..0 inside.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cylon_pos <= '0;
            cylon_up  <= 1'b1;
        end else if (mode_st != MANUAL) begin
            cylon_pos <= '0;
            cylon_up  <= 1'b1;
        end else if (cylon_step && (NUM_LEDS > 1)) begin
            if (cylon_up) begin
                if (cylon_pos == POS_LAST) begin
                    cylon_up  <= 1'b0;
                    cylon_pos <= cylon_pos - 1'b1;
                end else begin
                    cylon_pos <= cylon_pos + 1'b1;
                end
            end else begin
                if (cylon_pos == '0) begin
                    cylon_up  <= 1'b1;
                    cylon_pos <= cylon_pos + 1'b1;
                end else begin
                    cylon_pos <= cylon_pos - 1'b1;
                end
            end
        end
    end

    // Active-high pattern per mode; polarity applied at the output.
    always_comb begin
        pattern = '0;
        case (mode_st)
            WAIT:    pattern[0] = led_cnt[BLINK_BIT];
            MANUAL:  pattern    = NUM_LEDS'(1) << cylon_pos;
            BOOT:    pattern    = '1;
            default: pattern    = '0;
        endcase
    end

    assign led = LED_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/tinydfu_boot_ctrl.sv
// Boot/reset controller: holds the DFU core in reset, runs the auto-boot
// countdown, latches the boot image and drives the status LEDs.
module tinydfu_boot_ctrl
    import tinydfu_pkg::*;
#(
    parameter int         RESET_CYCLES   = 65535,
    parameter int         BOOT_TIMEOUT   = 60000000,
    parameter int         NUM_LEDS       = 4,
    parameter bit         LED_ACTIVE_LOW = 1'b1,
    parameter int         BLINK_BIT      = 21,
    parameter int         CYLON_BIT      = 20,
    parameter int         NUM_IMAGES     = 2,
    parameter logic [7:0] DFU_IDLE       = DFU_STATE_IDLE,
    parameter bit         REARM          = 1'b0,
    localparam int        IMG_W          = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          dfu_state,
    input  logic                dfu_detach,
    input  logic                btn_stay,
    input  logic [IMG_W-1:0]    img_sel,
    output logic                core_reset,
    output logic                boot_req,
    output logic [IMG_W-1:0]    boot_image,
    output logic                auto_armed,
    output logic [NUM_LEDS-1:0] led
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int TMO_W  = (BOOT_TIMEOUT > 1) ? $clog2(BOOT_TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(BOOT_TIMEOUT - 1);

    boot_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  countdown;
    logic [IMG_W-1:0]  img_clamped;
    logic              cancel;
    logic [1:0]        led_mode;

    // Out-of-range image requests fall back to image 0.
    assign img_clamped = (int'(img_sel) >= NUM_IMAGES) ? '0 : img_sel;
    assign cancel      = (dfu_state > DFU_IDLE) || btn_stay;
    assign led_mode    = state;

    // Boot FSM with hold counter, countdown and image latch; outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            countdown  <= '0;
            core_reset <= 1'b1;
            boot_req   <= 1'b0;
            boot_image <= '0;
            auto_armed <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= WAIT;
                        core_reset <= 1'b0;
                        countdown  <= TMO_LOAD;
                        auto_armed <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // Detach beats cancel, cancel beats expiry.
                    if (dfu_detach || (!cancel && countdown == '0)) begin
                        state      <= BOOT;
                        boot_req   <= 1'b1;
                        boot_image <= img_clamped;
                        auto_armed <= 1'b0;
                    end else if (cancel) begin
                        state      <= MANUAL;
                        auto_armed <= 1'b0;
                    end else begin
                        countdown <= countdown - 1'b1;
                    end
                end
                MANUAL: begin
                    if (dfu_detach) begin
                        state      <= BOOT;
                        boot_req   <= 1'b1;
                        boot_image <= img_clamped;
                    end else if (REARM && dfu_state == DFU_IDLE && !btn_stay) begin
                        state      <= WAIT;
                        countdown  <= TMO_LOAD;
                        auto_armed <= 1'b1;
                    end
                end
                BOOT: begin
                    state <= BOOT;
                end
                default: state <= HOLD;
            endcase
        end
    end

    tinydfu_led_pattern #(
        .NUM_LEDS       (NUM_LEDS),
        .BLINK_BIT      (BLINK_BIT),
        .CYLON_BIT      (CYLON_BIT),
        .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
    ) u_led (
        .clk    (clk),
        .resetn (resetn),
        .mode   (led_mode),
        .led    (led)
    );

endmodule

// File: tb/tb_tinydfu_boot_ctrl.sv
// Directed bench for tinydfu_boot_ctrl with small timing parameters.
// u_dut has REARM=0, u_rearm has REARM=1; both share all inputs.
module tb_tinydfu_boot_ctrl;

    localparam int RC = 4;
    localparam int BT = 10;
    localparam int NL = 4;
    localparam int NI = 3;
    localparam int IW = 2;

    logic          clk;
    logic          resetn;
    logic [7:0]    dfu_state;
    logic          dfu_detach;
    logic          btn_stay;
    logic [IW-1:0] img_sel;

    logic          core_reset, boot_req, auto_armed;
    logic [IW-1:0] boot_image;
    logic [NL-1:0] led;
    logic          r_core_reset, r_boot_req, r_auto_armed;
    logic [IW-1:0] r_boot_image;
    logic [NL-1:0] r_led;

    int tests = 0;
    int fails = 0;

    tinydfu_boot_ctrl #(
        .RESET_CYCLES(RC), .BOOT_TIMEOUT(BT), .NUM_LEDS(NL), .LED_ACTIVE_LOW(1'b1),
        .BLINK_BIT(2), .CYLON_BIT(1), .NUM_IMAGES(NI), .DFU_IDLE(8'h02), .REARM(1'b0)
    ) u_dut (
        .clk(clk), .resetn(resetn), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
        .btn_stay(btn_stay), .img_sel(img_sel), .core_reset(core_reset),
        .boot_req(boot_req), .boot_image(boot_image), .auto_armed(auto_armed), .led(led)
    );

    tinydfu_boot_ctrl #(
        .RESET_CYCLES(RC), .BOOT_TIMEOUT(BT), .NUM_LEDS(NL), .LED_ACTIVE_LOW(1'b1),
        .BLINK_BIT(2), .CYLON_BIT(1), .NUM_IMAGES(NI), .DFU_IDLE(8'h02), .REARM(1'b1)
    ) u_rearm (
        .clk(clk), .resetn(resetn), .dfu_state(dfu_state), .dfu_detach(dfu_detach),
        .btn_stay(btn_stay), .img_sel(img_sel), .core_reset(r_core_reset),
        .boot_req(r_boot_req), .boot_image(r_boot_image), .auto_armed(r_auto_armed), .led(r_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with idle inputs, then release just after a rising edge.
    task automatic release_reset();
        resetn     = 1'b0;
        dfu_state  = 8'h00;
        dfu_detach = 1'b0;
        btn_stay   = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; dfu_state = 8'h00; dfu_detach = 1'b0; btn_stay = 1'b0; img_sel = 2'd2;
        tick();
        tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL reset_boot_req got %b want 0", boot_req); end
        tests++; if (boot_image !== 2'd0) begin fails++; $display("FAIL reset_boot_image got %0d want 0", boot_image); end
        tests++; if (auto_armed !== 1'b0) begin fails++; $display("FAIL reset_auto_armed got %b want 0", auto_armed); end
        tests++; if (led !== 4'b1111) begin fails++; $display("FAIL reset_led got %b want 1111", led); end
    endtask

    task automatic test_autoboot();
        img_sel = 2'd2;
        release_reset();
        tick(); tick(); tick();
        tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL auto_core_reset_c3 got %b want 1", core_reset); end
        tick();
        tests++; if (core_reset !== 1'b0) begin fails++; $display("FAIL auto_core_reset_c4 got %b want 0", core_reset); end
        tests++; if (auto_armed !== 1'b1) begin fails++; $display("FAIL auto_armed_wait got %b want 1", auto_armed); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) begin
                tests++; if (led !== 4'b1110) begin fails++; $display("FAIL auto_blink_on got %b want 1110", led); end
            end
            if (i == 5) begin
                tests++; if (led !== 4'b1111) begin fails++; $display("FAIL auto_blink_off got %b want 1111", led); end
            end
        end
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL auto_early_boot got %b want 0", boot_req); end
        tick();
        tests++; if (boot_req !== 1'b1) begin fails++; $display("FAIL auto_boot_req got %b want 1", boot_req); end
        tests++; if (boot_image !== 2'd2) begin fails++; $display("FAIL auto_boot_image got %0d want 2", boot_image); end
        tests++; if (led !== 4'b0000) begin fails++; $display("FAIL auto_boot_led got %b want 0000", led); end
        tests++; if (auto_armed !== 1'b0) begin fails++; $display("FAIL auto_armed_boot got %b want 0", auto_armed); end
    endtask

    task automatic test_detach_hold();
        img_sel = 2'd1;
        release_reset();
        dfu_detach = 1'b1;
        tick();
        dfu_detach = 1'b0;
        tests++; if (boot_req !== 1'b0 || core_reset !== 1'b1) begin
            fails++; $display("FAIL hold_detach boot_req=%b core_reset=%b want 0/1", boot_req, core_reset);
        end
        tick(); tick(); tick();
        tests++; if (core_reset !== 1'b0 || auto_armed !== 1'b1) begin
            fails++; $display("FAIL hold_detach_wait core_reset=%b auto_armed=%b want 0/1", core_reset, auto_armed);
        end
    endtask

    task automatic test_cancel_and_detach();
        logic [3:0] seen [6];
        logic [3:0] exp_cyl [6];
        int n;
        logic boot_seen;
        exp_cyl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101};
        for (int i = 0; i < 6; i++) seen[i] = 4'h0;
        img_sel = 2'd1;
        release_reset();
        for (int i = 0; i < 6; i++) tick();
        dfu_state = 8'h05;
        tick();
        tests++; if (auto_armed !== 1'b0) begin fails++; $display("FAIL cancel_armed got %b want 0", auto_armed); end
        seen[0] = led; n = 1; boot_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (boot_req) boot_seen = 1'b1;
            if (n < 6 && led !== seen[n-1]) begin seen[n] = led; n++; end
        end
        tests++; if (boot_seen !== 1'b0) begin fails++; $display("FAIL cancel_no_boot got %b want 0", boot_seen); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (seen[i] !== exp_cyl[i]) begin
                fails++; $display("FAIL cylon_step%0d got %b want %b", i, seen[i], exp_cyl[i]);
            end
        end
        img_sel = 2'd3;
        dfu_detach = 1'b1;
        tick();
        dfu_detach = 1'b0;
        tests++; if (boot_req !== 1'b1) begin fails++; $display("FAIL manual_detach_boot got %b want 1", boot_req); end
        tests++; if (boot_image !== 2'd0) begin fails++; $display("FAIL manual_detach_clamp got %0d want 0", boot_image); end
        img_sel = 2'd1;
        tick();
        tests++; if (boot_req !== 1'b1 || boot_image !== 2'd0) begin
            fails++; $display("FAIL boot_sticky boot_req=%b image=%0d want 1/0", boot_req, boot_image);
        end
    endtask

    task automatic test_expiry_races();
        img_sel = 2'd0;
        release_reset();
        for (int i = 0; i < 13; i++) tick();
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL race_pre_boot got %b want 0", boot_req); end
        dfu_detach = 1'b1; img_sel = 2'd1;
        tick();
        dfu_detach = 1'b0;
        tests++; if (boot_req !== 1'b1 || boot_image !== 2'd1) begin
            fails++; $display("FAIL race_detach boot_req=%b image=%0d want 1/1", boot_req, boot_image);
        end
        release_reset();
        for (int i = 0; i < 13; i++) tick();
        btn_stay = 1'b1;
        tick();
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL race_cancel_boot got %b want 0", boot_req); end
        tests++; if (led !== 4'b1110 || auto_armed !== 1'b0) begin
            fails++; $display("FAIL race_cancel_manual led=%b armed=%b want 1110/0", led, auto_armed);
        end
        btn_stay = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL race_cancel_stays got %b want 0", boot_req); end
    endtask

    task automatic test_rearm();
        img_sel = 2'd2;
        release_reset();
        for (int i = 0; i < 5; i++) tick();
        dfu_state = 8'h05;
        tick();
        tests++; if (r_auto_armed !== 1'b0) begin fails++; $display("FAIL rearm_manual got %b want 0", r_auto_armed); end
        tick(); tick(); tick();
        dfu_state = 8'h02;
        tick();
        tests++; if (r_auto_armed !== 1'b1) begin fails++; $display("FAIL rearm_back_wait got %b want 1", r_auto_armed); end
        tests++; if (auto_armed !== 1'b0) begin fails++; $display("FAIL norearm_stays got %b want 0", auto_armed); end
        for (int i = 0; i < 9; i++) tick();
        tests++; if (r_boot_req !== 1'b0) begin fails++; $display("FAIL rearm_early_boot got %b want 0", r_boot_req); end
        tick();
        tests++; if (r_boot_req !== 1'b1 || r_boot_image !== 2'd2) begin
            fails++; $display("FAIL rearm_boot boot_req=%b image=%0d want 1/2", r_boot_req, r_boot_image);
        end
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL norearm_no_boot got %b want 0", boot_req); end
    endtask

    task automatic test_async_reset();
        img_sel = 2'd2;
        release_reset();
        for (int i = 0; i < 14; i++) tick();
        tests++; if (boot_req !== 1'b1) begin fails++; $display("FAIL async_pre_boot got %b want 1", boot_req); end
        #2 resetn = 1'b0;
        #1;
        tests++; if (core_reset !== 1'b1 || boot_req !== 1'b0 || boot_image !== 2'd0 || auto_armed !== 1'b0 || led !== 4'b1111) begin
            fails++; $display("FAIL async_boot cr=%b br=%b img=%0d arm=%b led=%b want 1/0/0/0/1111",
                              core_reset, boot_req, boot_image, auto_armed, led);
        end
        tick();
        resetn = 1'b1;
        tick(); tick(); tick();
        tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL async_rel_c3 got %b want 1", core_reset); end
        tick();
        tests++; if (core_reset !== 1'b0) begin fails++; $display("FAIL async_rel_c4 got %b want 0", core_reset); end
        for (int i = 0; i < 9; i++) tick();
        tests++; if (boot_req !== 1'b0) begin fails++; $display("FAIL async_rel_early got %b want 0", boot_req); end
        tick();
        tests++; if (boot_req !== 1'b1) begin fails++; $display("FAIL async_rel_boot got %b want 1", boot_req); end
        release_reset();
        for (int i = 0; i < 7; i++) tick();
        #2 resetn = 1'b0;
        #1;
        tests++; if (core_reset !== 1'b1 || auto_armed !== 1'b0 || led !== 4'b1111) begin
            fails++; $display("FAIL async_wait cr=%b arm=%b led=%b want 1/0/1111", core_reset, auto_armed, led);
        end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++; if (core_reset !== 1'b0 || auto_armed !== 1'b1) begin
            fails++; $display("FAIL async_wait_rel cr=%b arm=%b want 0/1", core_reset, auto_armed);
        end
    endtask

    initial begin
        test_reset();
        test_autoboot();
        test_detach_hold();
        test_cancel_and_detach();
        test_expiry_races();
        test_rearm();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tinydfu_boot_ctrl.md
# tinydfu_boot_ctrl

Parametrised boot/reset controller for TinyDFU board tops. It runs in the `clk` domain beside `usb_dfu_core` and holds the core in reset after power-up. It runs the auto-boot countdown and decides when to release the user image, including which image to release. It also drives the status LEDs with synchronous strobes instead of derived clocks. New relative to the per-board glue: LED count, timeout and image count are parameters, a stay-in-bootloader button is supported, and auto-boot can re-arm.

## Interface
- `RESET_CYCLES`, 65535: cycles `core_reset` is held after `resetn` release
- `BOOT_TIMEOUT`, 60000000: auto-boot countdown in cycles (5 s at 12 MHz)
- `NUM_LEDS`, 4: LED count, ≥1
- `LED_ACTIVE_LOW`, 1: invert `led`
- `BLINK_BIT`, 21: idle blink toggles every 2^BLINK_BIT cycles
- `CYLON_BIT`, 20: cylon steps every 2^CYLON_BIT cycles
- `NUM_IMAGES`, 2: selectable boot images, ≥1; `IMG_W = max(1, $clog2(NUM_IMAGES))`
- `DFU_IDLE`, 8'h02: dfu_state value meaning dfuIDLE
- `REARM`, 0: 1 = return to countdown when DFU goes back to idle
- `clk`  in  1  system clock (12 MHz typical)
- `resetn`  in  1  asynchronous, active-low reset
- `dfu_state`  in  8  DFU state from `usb_dfu_core`
- `dfu_detach`  in  1  single-cycle detach pulse
- `btn_stay`  in  1  synchronised button; high = cancel auto-boot
- `img_sel`  in  IMG_W  requested image; values ≥NUM_IMAGES clamp to 0
- `core_reset`  out  1  active-high reset to the USB/DFU core
- `boot_req`  out  1  sticky boot request; board top drives reconfig/resetn pin from it
- `boot_image`  out  IMG_W  image latched when boot is requested
- `auto_armed`  out  1  countdown running
- `led`  out  NUM_LEDS  status pattern

## Operation
- States: HOLD, WAIT, MANUAL, BOOT.
- In reset: state HOLD, `core_reset`=1, `boot_req`=0, `boot_image`=0, `auto_armed`=0, `led`=all off after polarity, all counters 0.
- HOLD: the hold counter counts to RESET_CYCLES-1, then moves to WAIT.
  - On entering WAIT: `core_reset` deasserts and the countdown loads BOOT_TIMEOUT-1.
  - `dfu_detach` is ignored in HOLD.
- WAIT: `auto_armed`=1 and the countdown decrements each cycle. Priority order:
  - (1) `dfu_detach` → BOOT.
  - (2) `dfu_state` > DFU_IDLE or `btn_stay` → MANUAL.
  - (3) countdown == 0 → BOOT.
- MANUAL: `auto_armed`=0.
  - `dfu_detach` → BOOT.
  - If REARM=1, `dfu_state` == DFU_IDLE and `btn_stay`=0 → WAIT with a full reload.
- BOOT: terminal until `resetn`. `boot_req`=1, `core_reset`=0, and `boot_image` is held.
- `boot_image` captures the clamped `img_sel` on the transition into BOOT only.
- LEDs, with polarity applied last:
  - HOLD: all off.
  - WAIT: LED0 blinks, the rest are off.
  - MANUAL: cylon, with one lit LED bouncing 0→N-1→0 over a period of 2·(N-1) steps. When NUM_LEDS=1 the cylon is LED0 steady on.
  - BOOT: all on.
- The free-running LED counter is 32-bit, wraps, and is not cleared on state change.
- The cylon position resets to 0 on entering MANUAL.

## Timing
- All outputs are registered and update one cycle after the triggering input is sampled.
- `core_reset` falls on the cycle RESET_CYCLES after `resetn` rises.
- Auto-boot: `boot_req` rises exactly BOOT_TIMEOUT cycles after WAIT entry.
- Detach: `boot_req` rises on the cycle after the `dfu_detach` pulse.
- Detach and countdown expiry in the same cycle → BOOT with the same image. Cancel and expiry in the same cycle → MANUAL.
- `resetn` assertion mid-countdown or in BOOT returns all state to reset values asynchronously.
- The cylon advances on the cycle where LED counter bit CYLON_BIT toggles, i.e. a single-cycle enable.

## Structure
- The shared package `tinydfu_pkg` holds the state enum `boot_state_t` (HOLD, WAIT, MANUAL, BOOT) and the constant `DFU_STATE_IDLE`=8'h02.
- Sub-module `tinydfu_led_pattern` takes NUM_LEDS, BLINK_BIT, CYLON_BIT and LED_ACTIVE_LOW, plus a 2-bit mode input. It owns the LED counter and the cylon.
- The top module keeps the FSM, the hold counter, the countdown and the image latch.

## Test plan
Parameters for all scenarios: RESET_CYCLES=4, BOOT_TIMEOUT=10, NUM_LEDS=4, BLINK_BIT=2, CYLON_BIT=1, NUM_IMAGES=3, unless noted.
- Power-up, no activity: `core_reset` falls 4 cycles after `resetn` rises. `boot_req` rises 10 cycles later with `boot_image`=`img_sel`=2. All LEDs lit (active-low 0000).
- Set `dfu_state`=8'h05 at WAIT cycle 3: `auto_armed`→0, no boot after 20 cycles, cylon shows 0001,0010,0100,1000,0100,0010 (inverted).
- REARM=1: `dfu_state` 05 then back to 02: state returns to WAIT, and `boot_req` rises 10 cycles after that return.
- Pulse `dfu_detach` during HOLD: no effect. Pulse it in MANUAL with `img_sel`=3: `boot_req`=1 next cycle and `boot_image`=0 (clamped).
- In the same cycle as countdown==0: `dfu_detach` gives BOOT; separately, `btn_stay` gives MANUAL with `boot_req`=0.
- Assert `resetn`=0 in BOOT and mid-countdown: outputs return to their reset values immediately, and the full sequence repeats after release.
